registered_ripple_adder: RTL and testbench

- WIDTH-bit ripple-carry adder with carry-in, built from a chain of 1-bit full-adder cells (S = A^B^Ci, Co = AB | Ci(A^B)).
- Operands are captured with a valid strobe. Sum, carry-out and status flags are registered one clock later.
- Serves as the datapath adder for arithmetic units that need a clean, registered sum and carry pair.

---
 rtl/registered_ripple_adder.sv | 72 +++++++
 tb/tb_registered_ripple_adder.sv | 116 +++++++++++
 2 files changed

// File: rtl/registered_ripple_adder.sv
// WIDTH-bit ripple-carry adder with carry-in; sum, carry-out and flags registered one clock after in_valid.
// One result per clock, no stalls and no backpressure; async reset clears all outputs.
module registered_ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] add_sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign add_sum[i]  = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]  = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic             overflow_d,  overflow_q;
  logic             zero_d,      zero_q;

  // Result registers only load on a valid strobe; out_valid is a single-cycle flag per capture.
  always_comb begin
    out_valid_d = in_valid;
    sum_d       = sum_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    if (in_valid) begin
      sum_d      = add_sum;
      cout_d     = carry[WIDTH];
      overflow_d = carry[WIDTH] ^ carry[WIDTH-1];
      zero_d     = (add_sum == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_registered_ripple_adder.sv
// Directed and swept checks of registered_ripple_adder (WIDTH=8) with immediate assertions.
module tb_registered_ripple_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic       cin;
  logic       out_valid;
  logic [7:0] sum;
  logic       cout, overflow, zero;

  int tests = 0;
  int fails = 0;

  registered_ripple_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Packed observation: {out_valid, cout, overflow, zero, sum}
  function automatic logic [11:0] obs();
    return {out_valid, cout, overflow, zero, sum};
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] o;
    o = obs();
    tests++;
    assert (o === exp) else begin
      fails++;
      $error("FAIL %s observed {v,co,ov,z,sum}=%b_%b_%b_%b_%h expected %b_%b_%b_%b_%h",
             tag, o[11], o[10], o[9], o[8], o[7:0], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic c);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model(input logic [7:0] av, input logic [7:0] bv, input logic c);
    logic [8:0] full;
    logic       ov;
    full = {1'b0, av} + {1'b0, bv} + {8'b0, c};
    ov   = (av[7] == bv[7]) && (full[7] != av[7]);
    return {1'b1, full[8], ov, (full[7:0] == 8'h00), full[7:0]};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    #1;
    check("reset_t1", 12'b0000_0000_0000);
    @(posedge clk); #1;
    check("reset_held", 12'b0000_0000_0000);
    @(negedge clk);
    rst = 1'b0;

    // {v,co,ov,z,sum} expectations computed by hand
    drive(1'b1, 8'h00, 8'h00, 1'b0); check("zero_add",    {4'b1001, 8'h00});
    drive(1'b1, 8'hFF, 8'h01, 1'b0); check("wrap_carry",  {4'b1101, 8'h00});
    drive(1'b1, 8'h7F, 8'h01, 1'b0); check("pos_ovf",     {4'b1010, 8'h80});
    drive(1'b1, 8'h80, 8'h80, 1'b0); check("neg_ovf",     {4'b1111, 8'h00});
    drive(1'b1, 8'h80, 8'hFF, 1'b0); check("neg_ovf2",    {4'b1110, 8'h7F});
    drive(1'b1, 8'h40, 8'h3F, 1'b1); check("cin_ovf",     {4'b1010, 8'h80});
    drive(1'b1, 8'h12, 8'h34, 1'b0); check("plain",       {4'b1000, 8'h46});
    drive(1'b1, 8'hFF, 8'hFF, 1'b1); check("all_ones",    {4'b1100, 8'hFF});
    drive(1'b0, 8'h01, 8'h02, 1'b0); check("idle_hold",   {4'b0100, 8'hFF});
    drive(1'b0, 8'h00, 8'h00, 1'b1); check("idle_hold2",  {4'b0100, 8'hFF});
    drive(1'b1, 8'h00, 8'h00, 1'b1); check("cin_only",    {4'b1000, 8'h01});

    // Back-to-back sweep: every a, 16 spread b values, both carry-ins
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          drive(1'b1, 8'(ai), 8'(bi * 17), 1'(ci));
          check("sweep", model(8'(ai), 8'(bi * 17), 1'(ci)));
        end
      end
    end

    for (int k = 0; k < 2000; k++) begin
      logic [7:0] ra, rb;
      logic       rc, rv;
      logic [11:0] prev;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rv = ($urandom_range(0, 3) != 0);
      prev = obs();
      drive(rv, ra, rb, rc);
      if (rv) check("random", model(ra, rb, rc));
      else    check("random_idle", {1'b0, prev[10:0]});
    end

    // Half-cycle reset while in_valid is high
    drive(1'b1, 8'h12, 8'h34, 1'b0); check("pre_reset", {4'b1000, 8'h46});
    @(negedge clk);
    a = 8'h55; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    #1 rst = 1'b1;
    #1 check("mid_reset", 12'b0000_0000_0000);
    #2 rst = 1'b0;
    #0 check("post_release", 12'b0000_0000_0000);
    @(posedge clk); #1;
    check("resume", {4'b1000, 8'h56});
    drive(1'b0, 8'h00, 8'h00, 1'b0); check("resume_idle", {4'b0000, 8'h56});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
